mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
- Parametrised successor to the memory stage's fixed, read-only unified-memory hookup.
- Arbitrates NUM_REQ requesters (i-cache, d-cache, future DMA) onto one unified-memory port, round-robin fairness.
- Supports reads and writes, one outstanding transaction, variable memory latency via mem_rdy.
- Sits between the cache controllers and unified_mem.

Parameters:
NUM_REQ, 2, number of requesting channels (2..8)
ADDR_W, 16, address width
DATA_W, 16, data width
TIMEOUT, 64, max cycles waiting on mem_rdy (MEM_TIMEOUT_EN only)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-channel request valid
req_rw  input  NUM_REQ  per-channel direction, 1=write, 0=read
req_addr  input  NUM_REQ*ADDR_W  flattened addresses, channel i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  flattened write data, same packing
req_accept  output  NUM_REQ  one-hot, request latched this cycle
resp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse
resp_data  output  DATA_W  read data, valid with resp_valid
resp_err  output  1  completion was a timeout (0 when macro off)
mem_addr  output  ADDR_W  unified-memory address
mem_re  output  1  unified-memory read enable
mem_we  output  1  unified-memory write enable
mem_wdata  output  DATA_W  unified-memory write data
mem_rdy  input  1  unified memory has completed access
mem_rdata  input  DATA_W  unified-memory read data
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=NUM_REQ-1 (channel 0 wins first). All outputs 0. Latched addr/data/rw/id cleared.
- FSM states IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first set bit searching from rr_ptr+1 mod NUM_REQ upward with wrap.
  - req_accept[grant]=1 combinationally this cycle.
  - Latch addr, wdata, rw and id; next state WAIT.
  - No valid requests: remain in IDLE, req_accept=0.
- WAIT:
  - mem_addr and mem_wdata driven from latches, stable for the whole state.
  - mem_re=!rw and mem_we=rw, held high until mem_rdy is sampled 1.
  - On mem_rdy=1: capture mem_rdata when rw=0; next state RESP.
- RESP:
  - resp_valid[id]=1 for exactly one cycle; mem_re=mem_we=0.
  - resp_data holds the captured read data until the next read completion.
  - On a write completion resp_data is unchanged.
  - rr_ptr<=id; next state IDLE.
- No request is accepted in WAIT or RESP; req_valid is ignored there, and requesters hold requests until accepted.
- mem_rdy outside WAIT is ignored.
- Latency:
  - Request sampled in cycle 0, mem_re/mem_we asserted from cycle 1.
  - mem_rdy in cycle k (k>=1) gives resp_valid in cycle k+1.
  - Next accept is possible no earlier than cycle k+2.
- Requester dropping req_valid after accept has no effect; the transaction completes.
- Requester whose req_valid stays asserted after accept is treated as a new request at the next IDLE.
- A single active requester is granted back-to-back; round-robin only matters under contention.
- Reset asserted in WAIT/RESP aborts immediately: no resp_valid, mem_re/mem_we drop asynchronously.
- busy=1 in WAIT and RESP.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A cycle counter, width clog2(TIMEOUT+1), clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mem_rdy, go to RESP with resp_err=1 (one cycle with resp_valid) and resp_data unchanged.
  - resp_err=0 on normal completions.
- Undefined: no counter; WAIT lasts indefinitely; resp_err tied 0.

Test Plan:
- Single read: ch0 req_valid=1, rw=0, addr=0x0040; memory asserts mem_rdy 4 cycles after mem_re with rdata=0xBEEF -> req_accept=01 at cycle 0, mem_re cycles 1-4, resp_valid=01 at cycle 5, resp_data=0xBEEF.
- Write: ch1 rw=1, addr=0x1234, wdata=0xA5A5 -> mem_we=1, mem_addr=0x1234, mem_wdata=0xA5A5 until mem_rdy, resp_valid=10, resp_data unchanged.
- Contention: ch0 and ch1 held valid continuously, 1-cycle memory -> grants alternate 0,1,0,1 over four transactions.
- Async reset in WAIT: assert rst mid-access -> mem_re=0 before next clk edge, no resp_valid, next grant goes to ch0.
- Spurious mem_rdy=1 in IDLE -> no state change, no resp_valid.
- MEM_TIMEOUT_EN, TIMEOUT=8, mem_rdy never asserted -> resp_valid and resp_err=1 exactly 9 cycles after accept, then IDLE.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Round-robin arbiter placing NUM_REQ requesters (i-cache, d-cache, DMA)
// onto one unified-memory port. One transaction outstanding at a time;
// memory latency is open-ended and signalled by mem_rdy.
// Optional feature macro: MEM_TIMEOUT_EN bounds the wait on mem_rdy to
// TIMEOUT cycles and reports the abort through resp_err.
module mem_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_accept,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_rdy,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   idx;
  logic              gnt_found;
  logic              take;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rw_q;
  logic              err_q;
  logic              timeout_hit;

  // Round-robin search: first valid channel after the one served last, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end else begin
        gnt_id    = gnt_id;
      end
    end
  end

  // A request is only taken while idle; reset masks the combinational grant.
  assign take = (state == IDLE) && gnt_found && !rst;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Count cycles spent in WAIT; held at zero outside so each access starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Abort on the WAIT cycle whose increment would make the count reach TIMEOUT.
  assign timeout_hit = (state == WAIT) && !mem_rdy &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (mem_rdy || timeout_hit) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the granted request so the memory sees stable values during WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      id_q    <= '0;
    end else if (take) begin
      addr_q  <= req_addr[gnt_id*ADDR_W +: ADDR_W];
      wdata_q <= req_wdata[gnt_id*DATA_W +: DATA_W];
      rw_q    <= req_rw[gnt_id];
      id_q    <= gnt_id;
    end else begin
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
      rw_q    <= rw_q;
      id_q    <= id_q;
    end
  end

  // Read data is kept until the next read completes; writes and timeouts leave it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if ((state == WAIT) && mem_rdy && !rw_q) begin
      rdata_q <= mem_rdata;
    end else begin
      rdata_q <= rdata_q;
    end
  end

  // Remember whether the access ended by timeout, for the completion cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == WAIT) begin
      err_q <= timeout_hit;
    end else begin
      err_q <= err_q;
    end
  end

  // Round-robin pointer moves to the channel just served on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else if (state == RESP) begin
      rr_ptr <= id_q;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  // Outputs decode directly from the state register, so reset clears them at once.
  assign req_accept = take ? (ONE << gnt_id) : '0;
  assign mem_re     = (state == WAIT) && !rw_q;
  assign mem_we     = (state == WAIT) && rw_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_valid = (state == RESP) ? (ONE << id_q) : '0;
  assign resp_data  = rdata_q;
  assign resp_err   = (state == RESP) && err_q;
  assign busy       = (state != IDLE);

endmodule
